// File: rtl/last_stage_seq.sv
// Purpose : sequential last stage of the modulo (2^N-1) adder/subtractor. Checks
//           every dual-rail pair of a[N-1:0] / b[N:1], then resolves A + 2*B
//           bit-serially (LSB first) with end-around carry into a binary residue.
// Latency : the accept edge plus N+1 further edges to out_valid (N+2 edges, 6 for
//           N=4). An illegal rail code gives out_valid on the edge after accept.
//           One result every N+3 cycles while out_ready is held high.
// Backpressure: in_ready is high only in IDLE. z/err/out_valid hold in DONE until
//           out_ready. in_valid is ignored outside IDLE. Inputs are captured on the
//           accept edge and need not be held after it.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready with rails a_t/a_f
//           (a[N-1:0]) and b_t/b_f (b[N:1], bit k = b_(k+1)); out_valid/out_ready
//           with z (residue) and err (illegal rail code); busy (ADD or FIX).
// Option  : define LAST_STAGE_NEG_ZERO_NORM_EN to map the all-ones residue
//           (negative zero) to 0 in FIX.
module last_stage_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_t,
  input  logic [N-1:0] a_f,
  input  logic [N-1:0] b_t,
  input  logic [N-1:0] b_f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic         err,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;      // a operand, shifted right each ADD cycle
  logic [N-1:0]  b_q, b_d;      // b aligned to weight i (b_0 = 0), shifted likewise
  logic [N-1:0]  acc_q, acc_d;  // sum bits shift in at the MSB
  logic [N-1:0]  z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;

  logic          illegal;
  logic [1:0]    bit_sum;
  logic [N-1:0]  fix_sum;
  logic [N-1:0]  fix_res;

  // A pair is legal only when its rails differ.
  assign illegal = |(a_t ~^ a_f) | |(b_t ~^ b_f);

  assign bit_sum = {1'b0, a_q[0]} + {1'b0, b_q[0]} + {1'b0, carry_q};

  // Pre-fix low part is at most 2^N-2, so adding the final carry cannot overflow.
  assign fix_sum = acc_q + {{(N-1){1'b0}}, carry_q};

`ifdef LAST_STAGE_NEG_ZERO_NORM_EN
  assign fix_res = (&fix_sum) ? '0 : fix_sum;
`else
  assign fix_res = fix_sum;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (illegal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            z_d     = '0;
          end else begin
            state_d = S_ADD;
            err_d   = 1'b0;
            a_d     = a_t;
            // b_t[k] has weight 2^(k+1); shifting left lines it up with a.
            b_d     = b_t << 1;
            // b_N has weight 2^N == 1 mod (2^N-1): it enters as the initial carry.
            carry_d = b_t[N-1];
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_ADD: begin
        acc_d   = {bit_sum[0], acc_q[N-1:1]};
        carry_d = bit_sum[1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        z_d     = fix_res;
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ADD) || (state_q == S_FIX);
  assign z         = z_q;
  assign err       = err_q;

endmodule

// File: tb/tb_last_stage_seq.sv
module tb_last_stage_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a_t = '0, a_f = '0, b_t = '0, b_f = '0;
  logic       in_ready, out_valid, err, busy;
  logic [3:0] z;

  int cmp = 0;
  int nfail = 0;

`ifdef LAST_STAGE_NEG_ZERO_NORM_EN
  localparam logic [3:0] NZ = 4'b0000;
`else
  localparam logic [3:0] NZ = 4'b1111;
`endif

  last_stage_seq #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one vector for a single cycle (DUT must be in IDLE) and returns the
  // number of edges, counting the accept edge as 1, until out_valid is seen.
  task automatic send(input logic [3:0] at, input logic [3:0] af,
                      input logic [3:0] bt, input logic [3:0] bf, output int edges);
    @(negedge clk);
    a_t = at; a_f = af; b_t = bt; b_f = bf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_t = '0; a_f = '0; b_t = '0; b_f = '0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    cmp++; if (in_ready !== 1'b1)  begin nfail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    cmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    cmp++; if (z !== 4'b0000)      begin nfail++; $display("FAIL reset_z got %b want 0000", z); end
    cmp++; if (err !== 1'b0)       begin nfail++; $display("FAIL reset_err got %b want 0", err); end
    cmp++; if (busy !== 1'b0)      begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int e;
    send(4'b0101, 4'b1010, 4'b0000, 4'b1111, e);
    cmp++; if (e !== 6)        begin nfail++; $display("FAIL basic_latency got %0d want 6", e); end
    cmp++; if (z !== 4'b0101)  begin nfail++; $display("FAIL basic_z got %b want 0101", z); end
    cmp++; if (err !== 1'b0)   begin nfail++; $display("FAIL basic_err got %b want 0", err); end
    take();
  endtask

  task automatic test_carry();
    int e;
    // 12 + 2*(8+4) = 36 = 21+15 -> low 0101 plus end-around carry -> 0110
    send(4'b1100, 4'b0011, 4'b1100, 4'b0011, e);
    cmp++; if (e !== 6)        begin nfail++; $display("FAIL carry_latency got %0d want 6", e); end
    cmp++; if (z !== 4'b0110)  begin nfail++; $display("FAIL carry_z got %b want 0110", z); end
    take();
  endtask

  task automatic test_vectors();
    // {a, b[4:1], expected z}: 3+2*1=5, 6+2*2=10
    logic [11:0] tbl [2];
    int e;
    tbl[0] = {4'b0011, 4'b0001, 4'b0101};
    tbl[1] = {4'b0110, 4'b0010, 4'b1010};
    for (int i = 0; i < 2; i++) begin
      send(tbl[i][11:8], ~tbl[i][11:8], tbl[i][7:4], ~tbl[i][7:4], e);
      cmp++; if (z !== tbl[i][3:0]) begin nfail++; $display("FAIL vec%0d_z got %b want %b", i, z, tbl[i][3:0]); end
      cmp++; if (err !== 1'b0)      begin nfail++; $display("FAIL vec%0d_err got %b want 0", i, err); end
      take();
    end
  endtask

  task automatic test_neg_zero();
    int e;
    send(4'b1111, 4'b0000, 4'b0000, 4'b1111, e);
    cmp++; if (z !== NZ) begin nfail++; $display("FAIL negzero_a_z got %b want %b", z, NZ); end
    take();
    // 15 + 2*15 = 45 == 0 mod 15, arrives as 1110 + carry = 1111
    send(4'b1111, 4'b0000, 4'b1111, 4'b0000, e);
    cmp++; if (z !== NZ) begin nfail++; $display("FAIL negzero_ab_z got %b want %b", z, NZ); end
    take();
  endtask

  task automatic test_illegal();
    int e;
    send(4'b0101, 4'b1110, 4'b0000, 4'b1111, e);
    cmp++; if (e !== 1)       begin nfail++; $display("FAIL illegal_latency got %0d want 1", e); end
    cmp++; if (err !== 1'b1)  begin nfail++; $display("FAIL illegal_err got %b want 1", err); end
    cmp++; if (z !== 4'b0000) begin nfail++; $display("FAIL illegal_z got %b want 0000", z); end
    take();
    send(4'b0101, 4'b1010, 4'b0000, 4'b1111, e);
    cmp++; if (e !== 6)       begin nfail++; $display("FAIL after_illegal_latency got %0d want 6", e); end
    cmp++; if (err !== 1'b0)  begin nfail++; $display("FAIL after_illegal_err got %b want 0", err); end
    cmp++; if (z !== 4'b0101) begin nfail++; $display("FAIL after_illegal_z got %b want 0101", z); end
    take();
  endtask

  task automatic test_stall();
    int e;
    send(4'b1100, 4'b0011, 4'b1100, 4'b0011, e);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_t = 4'b1111; a_f = 4'b0000; b_t = 4'b0000; b_f = 4'b1111; in_valid = 1'b1;
      @(posedge clk); #1;
      cmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL stall%0d_out_valid got %b want 1", c, out_valid); end
      cmp++; if (z !== 4'b0110)      begin nfail++; $display("FAIL stall%0d_z got %b want 0110", c, z); end
      cmp++; if (err !== 1'b0)       begin nfail++; $display("FAIL stall%0d_err got %b want 0", c, err); end
      cmp++; if (in_ready !== 1'b0)  begin nfail++; $display("FAIL stall%0d_in_ready got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    take();
    cmp++; if (in_ready !== 1'b1)  begin nfail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    cmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL release_out_valid got %b want 0", out_valid); end
    cmp++; if (z !== 4'b0110)      begin nfail++; $display("FAIL release_z_hold got %b want 0110", z); end
  endtask

  task automatic test_reset_mid_add();
    int e;
    @(negedge clk);
    a_t = 4'b0101; a_f = 4'b1010; b_t = 4'b0000; b_f = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL midadd_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    cmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    cmp++; if (z !== 4'b0000)      begin nfail++; $display("FAIL rst_z got %b want 0000", z); end
    cmp++; if (in_ready !== 1'b1)  begin nfail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    cmp++; if (busy !== 1'b0)      begin nfail++; $display("FAIL rst_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0110, 4'b1001, 4'b0010, 4'b1101, e);
    cmp++; if (e !== 6)       begin nfail++; $display("FAIL post_rst_latency got %0d want 6", e); end
    cmp++; if (z !== 4'b1010) begin nfail++; $display("FAIL post_rst_z got %b want 1010", z); end
    take();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    @(negedge clk);
    out_ready = 1'b1;
    a_t = 4'b0011; a_f = 4'b1100; b_t = 4'b0001; b_f = 4'b1110; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) acc.push_back(c);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    cmp++; if (acc.size() !== 3) begin nfail++; $display("FAIL b2b_accepts got %0d want 3", acc.size()); end
    if (acc.size() >= 2) begin
      cmp++; if (acc[1] - acc[0] !== 7) begin nfail++; $display("FAIL b2b_period got %0d want 7", acc[1] - acc[0]); end
    end
    cmp++; if (z !== 4'b0101) begin nfail++; $display("FAIL b2b_z got %b want 0101", z); end
    take();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_carry();
    test_vectors();
    test_neg_zero();
    test_illegal();
    test_stall();
    test_reset_mid_add();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nfail);
    $finish;
  end

endmodule
